host_instr_unpacker: RTL and testbench

- Upstream feeder of the instruction receiver. Accepts a length-prefixed burst of wide host beats (PCIe/RIFFA-style valid/ready channel) and buffers them in a small beat FIFO.
- Serialises the buffered beats into the 32-bit app_en/app_ack/app_instr word stream consumed by the instruction receiver.
- Discards unused lanes of a partial final beat and reports completion.

---
 rtl/host_instr_unpacker_if.sv | 34 +++
 rtl/host_instr_unpacker.sv | 141 ++++++++++++++
 tb/tb_host_instr_unpacker.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/host_instr_unpacker_if.sv
// Host beat and instruction word channel bundle for host_instr_unpacker.
// master: host/receiver side; slave: the unpacker itself.
//   rx_start/rx_len/rx_busy       transfer control
//   rx_data/rx_valid/rx_ready     wide host beat handshake
//   app_en/app_ack/app_instr      32-bit word handshake
//   words_sent/xfer_done          progress and completion
interface host_instr_unpacker_if #(
    parameter int DATA_W = 128,
    parameter int LEN_W  = 32
);
    logic              rx_start;
    logic [LEN_W-1:0]  rx_len;
    logic              rx_busy;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              app_en;
    logic              app_ack;
    logic [31:0]       app_instr;
    logic [LEN_W-1:0]  words_sent;
    logic              xfer_done;

    modport master (
        output rx_start, rx_len, rx_data, rx_valid, app_ack,
        input  rx_busy, rx_ready, app_en, app_instr,
        input  words_sent, xfer_done
    );

    modport slave (
        input  rx_start, rx_len, rx_data, rx_valid, app_ack,
        output rx_busy, rx_ready, app_en, app_instr,
        output words_sent, xfer_done
    );
endinterface

// File: rtl/host_instr_unpacker.sv
// Buffers a length-prefixed burst of wide host beats in a small FIFO and
// serialises them, lane 0 first, into a 32-bit app_en/app_ack word stream.
// Ports: clk, rst (async, active high), bus (slave modport) carrying
//   rx_start/rx_len/rx_busy, rx_data/rx_valid/rx_ready,
//   app_en/app_ack/app_instr, words_sent, xfer_done.
module host_instr_unpacker #(
    parameter int DATA_W     = 128,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    host_instr_unpacker_if.slave  bus
);
    localparam int K      = DATA_W / 32;
    localparam int LANE_W = (K > 1) ? $clog2(K) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(K - 1);
    localparam logic [LEN_W-1:0]  K_LEN     = LEN_W'(K);
    localparam logic [LEN_W-1:0]  ONE_LEN   = LEN_W'(1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t              state;
    logic [LEN_W-1:0]    words_left;
    logic [LEN_W-1:0]    beats_left;
    logic [LEN_W-1:0]    words_sent_q;
    logic [LANE_W-1:0]   lane_idx;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                xfer_done_q;
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];

    logic                recv;
    logic                full;
    logic                empty;
    logic                rx_ready_c;
    logic                app_en_c;
    logic                push;
    logic                fire;
    logic                pop;
    logic                last_word;
    logic                last_lane;
    logic [LEN_W-1:0]    beats_total;
    logic [DATA_W-1:0]   head;
    logic [31:0]         lane_word;

    // Quotient plus a carry for a partial beat never exceeds the
    // quotient range, so the maximum rx_len cannot overflow.
    assign beats_total = (bus.rx_len / K_LEN)
                       + LEN_W'(|(bus.rx_len % K_LEN));

    assign recv       = (state == RECV);
    assign full       = (count == DEPTH_C);
    assign empty      = (count == '0);
    assign rx_ready_c = recv & ~full & (beats_left != '0);
    assign app_en_c   = recv & ~empty & (words_left != '0);
    assign push       = bus.rx_valid & rx_ready_c;
    assign fire       = app_en_c & bus.app_ack;
    assign last_word  = (words_left == ONE_LEN);
    assign last_lane  = (lane_idx == LANE_LAST);
    // The final word retires its beat even when lanes remain unread.
    assign pop        = fire & (last_lane | last_word);

    assign head       = mem[rd_ptr];
    assign lane_word  = head[32*int'(lane_idx) +: 32];

    assign bus.rx_busy    = recv;
    assign bus.rx_ready   = rx_ready_c;
    assign bus.app_en     = app_en_c;
    assign bus.app_instr  = app_en_c ? lane_word : '0;
    assign bus.words_sent = words_sent_q;
    assign bus.xfer_done  = xfer_done_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            words_left   <= '0;
            beats_left   <= '0;
            words_sent_q <= '0;
            lane_idx     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            xfer_done_q  <= 1'b0;
        end else begin
            xfer_done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.rx_start) begin
                        words_sent_q <= '0;
                        lane_idx     <= '0;
                        wr_ptr       <= '0;
                        rd_ptr       <= '0;
                        count        <= '0;
                        if (bus.rx_len != '0) begin
                            words_left <= bus.rx_len;
                            beats_left <= beats_total;
                            state      <= RECV;
                        end else begin
                            xfer_done_q <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (push) begin
                        wr_ptr     <= wr_ptr + PTR_W'(1);
                        beats_left <= beats_left - ONE_LEN;
                    end
                    if (pop) begin
                        rd_ptr <= rd_ptr + PTR_W'(1);
                    end
                    count <= count + CNT_W'(push) - CNT_W'(pop);
                    if (fire) begin
                        words_left   <= words_left - ONE_LEN;
                        words_sent_q <= words_sent_q + ONE_LEN;
                        lane_idx     <= pop ? '0 : lane_idx + LANE_W'(1);
                        if (last_word) begin
                            state       <= IDLE;
                            xfer_done_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_host_instr_unpacker.sv
// Directed bench for host_instr_unpacker: table of transfers plus
// hand sequences for zero length, back-to-back start and async reset.
module tb_host_instr_unpacker;
    localparam int DW = 128;
    localparam int FD = 4;
    localparam int LW = 32;
    localparam int K  = DW / 32;

    typedef struct {
        string nm;
        int    len;
        int    offer;
        bit    vgap;
        bit    arand;
        int    stall;
        bit    poke;
    } vec_t;

    logic clk;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;
    vec_t vecs [6];

    host_instr_unpacker_if #(.DATA_W(DW), .LEN_W(LW)) bus ();

    host_instr_unpacker #(
        .DATA_W(DW),
        .FIFO_DEPTH(FD),
        .LEN_W(LW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [31:0] word(input int tag, input int i);
        return {tag[15:0], i[15:0]};
    endfunction

    function automatic logic [DW-1:0] beat(input int tag, input int b);
        logic [DW-1:0] r;
        r = '0;
        for (int l = 0; l < K; l++) r[l*32 +: 32] = word(tag, b*K + l);
        return r;
    endfunction

    function automatic vec_t mk(input string nm, input int len,
                                input int offer, input bit vgap,
                                input bit arand, input int stall,
                                input bit poke);
        vec_t v;
        v.nm = nm; v.len = len; v.offer = offer; v.vgap = vgap;
        v.arand = arand; v.stall = stall; v.poke = poke;
        return v;
    endfunction

    // Called at posedge+1; starts the transfer in the current cycle.
    task automatic run_xfer(input vec_t v, input int tag);
        int acc = 0;
        int w = 0;
        int dn = 0;
        int cyc = 0;
        int first = -1;
        int last = -1;
        bit hold_v = 0;
        logic [31:0] hold = '0;
        int nb = (v.len + K - 1) / K;
        bus.rx_start = 1'b1;
        bus.rx_len = LW'(v.len);
        @(posedge clk); #1;
        bus.rx_start = 1'b0;
        chk({v.nm, "/busy"}, bus.rx_busy, 1);
        chk({v.nm, "/ws_clr"}, bus.words_sent, 0);
        while (dn == 0 && cyc < 2000) begin
            if (hold_v) begin
                chk({v.nm, "/hold_en"}, bus.app_en, 1);
                chk({v.nm, "/hold_instr"}, bus.app_instr, hold);
            end
            if (v.stall > 0 && cyc == v.stall) begin
                chk({v.nm, "/full_beats"}, acc, FD);
                chk({v.nm, "/full_rdy"}, bus.rx_ready, 0);
                chk({v.nm, "/full_head"}, bus.app_instr, word(tag, 0));
            end
            bus.rx_start = v.poke && cyc == 6;
            bus.rx_len = bus.rx_start ? LW'(3) : LW'(v.len);
            bus.rx_valid = (acc < v.offer) &&
                           (!v.vgap || $urandom_range(0, 2) != 0);
            bus.rx_data = beat(tag, acc);
            bus.app_ack = (cyc >= v.stall) &&
                          (!v.arand || $urandom_range(0, 1) == 1);
            if (bus.rx_valid && bus.rx_ready) acc++;
            if (bus.app_en && bus.app_ack) begin
                chk($sformatf("%s/word%0d", v.nm, w),
                    bus.app_instr, word(tag, w));
                w++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            hold_v = bus.app_en && !bus.app_ack;
            hold = bus.app_instr;
            @(posedge clk); #1;
            cyc++;
            if (bus.xfer_done) dn++;
        end
        bus.rx_start = 1'b0;
        bus.rx_valid = 1'b0;
        bus.app_ack = 1'b0;
        chk({v.nm, "/done"}, dn, 1);
        chk({v.nm, "/nwords"}, w, v.len);
        chk({v.nm, "/nbeats"}, acc, nb);
        chk({v.nm, "/ws"}, bus.words_sent, v.len);
        chk({v.nm, "/idle_busy"}, bus.rx_busy, 0);
        chk({v.nm, "/idle_en"}, bus.app_en, 0);
        if (!v.vgap && !v.arand && v.stall == 0)
            chk({v.nm, "/rate"}, last - first, v.len - 1);
        @(posedge clk); #1;
        chk({v.nm, "/done_once"}, bus.xfer_done, 0);
        chk({v.nm, "/ws_hold"}, bus.words_sent, v.len);
    endtask

    initial begin
        int w;
        int acc;
        int cyc;
        vecs[0] = mk("len8",   8,  2, 0, 0, 0,  0);
        vecs[1] = mk("len5",   5,  3, 0, 0, 0,  0);
        vecs[2] = mk("fill32", 32, 8, 0, 0, 20, 0);
        vecs[3] = mk("rand37", 37, 10, 1, 1, 0, 1);
        vecs[4] = mk("len1",   1,  1, 0, 0, 0,  0);
        vecs[5] = mk("len12",  12, 3, 0, 1, 0,  0);

        rst = 1'b1;
        bus.rx_start = 1'b0;
        bus.rx_len = '0;
        bus.rx_data = '0;
        bus.rx_valid = 1'b0;
        bus.app_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst/busy", bus.rx_busy, 0);
        chk("rst/ready", bus.rx_ready, 0);
        chk("rst/en", bus.app_en, 0);
        chk("rst/instr", bus.app_instr, 0);
        chk("rst/ws", bus.words_sent, 0);
        chk("rst/done", bus.xfer_done, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle/ready", bus.rx_ready, 0);

        bus.rx_start = 1'b1;
        bus.rx_len = '0;
        bus.app_ack = 1'b1;
        @(posedge clk); #1;
        bus.rx_start = 1'b0;
        chk("len0/done", bus.xfer_done, 1);
        chk("len0/busy", bus.rx_busy, 0);
        chk("len0/en", bus.app_en, 0);
        @(posedge clk); #1;
        bus.app_ack = 1'b0;
        chk("len0/done_once", bus.xfer_done, 0);
        chk("len0/busy2", bus.rx_busy, 0);

        for (int i = 0; i < 6; i++) run_xfer(vecs[i], i + 1);

        bus.rx_start = 1'b1;
        bus.rx_len = '0;
        @(posedge clk); #1;
        bus.rx_start = 1'b0;
        chk("b2b/done", bus.xfer_done, 1);
        run_xfer(mk("b2b", 4, 1, 0, 0, 0, 0), 'h20);

        bus.rx_start = 1'b1;
        bus.rx_len = LW'(12);
        @(posedge clk); #1;
        bus.rx_start = 1'b0;
        w = 0;
        acc = 0;
        cyc = 0;
        while (w < 3 && cyc < 50) begin
            bus.rx_valid = acc < 3;
            bus.rx_data = beat('h30, acc);
            bus.app_ack = 1'b1;
            if (bus.rx_valid && bus.rx_ready) acc++;
            if (bus.app_en && bus.app_ack) w++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("mr/words", w, 3);
        chk("mr/ws_pre", bus.words_sent, 3);
        chk("mr/en_pre", bus.app_en, 1);
        #2 rst = 1'b1;
        #1;
        chk("mr/busy", bus.rx_busy, 0);
        chk("mr/ready", bus.rx_ready, 0);
        chk("mr/en", bus.app_en, 0);
        chk("mr/instr", bus.app_instr, 0);
        chk("mr/ws", bus.words_sent, 0);
        chk("mr/done", bus.xfer_done, 0);
        bus.rx_valid = 1'b0;
        bus.app_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_xfer(mk("post_rst", 4, 1, 0, 0, 0, 0), 'h40);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
